// File: rtl/tmds_pkg.sv
// Shared types and constants for the three-channel DVI TMDS encoder.
package tmds_pkg;

   localparam int unsigned SYM_W  = 10;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 5;

   typedef logic [SYM_W-1:0]        sym_t;
   typedef logic signed [CNT_W-1:0] disp_t;

   typedef struct packed {
      logic [DATA_W-1:0] r;
      logic [DATA_W-1:0] g;
      logic [DATA_W-1:0] b;
   } pix_t;

   localparam sym_t CTRL_00 = 10'b1101010100;
   localparam sym_t CTRL_01 = 10'b0010101011;
   localparam sym_t CTRL_10 = 10'b0101010100;
   localparam sym_t CTRL_11 = 10'b1010101011;

   function automatic sym_t ctrl_sym(input logic [1:0] c);
      case (c)
         2'b00:   return CTRL_00;
         2'b01:   return CTRL_01;
         2'b10:   return CTRL_10;
         default: return CTRL_11;
      endcase
   endfunction

   // Eight-bar test pattern, left to right.
   function automatic pix_t bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return 24'hFFFFFF;
         3'd1:    return 24'hFFFF00;
         3'd2:    return 24'h00FFFF;
         3'd3:    return 24'h00FF00;
         3'd4:    return 24'hFF00FF;
         3'd5:    return 24'hFF0000;
         3'd6:    return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

endpackage

// File: rtl/tmds_if.sv
// Pixel-side bundle between a video timing source and the TMDS encoder.
interface tmds_if;
   import tmds_pkg::*;

   logic        de;
   logic [1:0]  vh;
   logic [10:0] x;
   logic [23:0] rgb;
   logic        pat_en;
   sym_t        tmds_b;
   sym_t        tmds_g;
   sym_t        tmds_r;

   modport master (output de, vh, x, rgb, pat_en, input tmds_b, tmds_g, tmds_r);
   modport slave  (input de, vh, x, rgb, pat_en, output tmds_b, tmds_g, tmds_r);
endinterface

// File: rtl/tmds_channel.sv
// One TMDS lane: transition minimisation (stage 1) and DC balancing (stage 2).
module tmds_channel
   import tmds_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              de_i,
   input  logic [1:0]        c_i,
   input  logic [DATA_W-1:0] d_i,
   output sym_t              sym_o
);

   logic [3:0] n1_c;
   logic       use_xnor_c;
   logic [8:0] q_m_c;

   logic [8:0] q_m_q;
   logic       de_q;
   logic [1:0] c_q;

   logic [3:0] n1m_c;
   disp_t      diff_c;
   sym_t       sym_d, sym_q;
   disp_t      cnt_d, cnt_q;

   // Stage 1: pick XOR or XNOR chain to minimise transitions.
   always_comb begin
      n1_c = '0;
      for (int i = 0; i < 8; i++) n1_c = n1_c + 4'(d_i[i]);
      use_xnor_c = (n1_c > 4'd4) || ((n1_c == 4'd4) && !d_i[0]);
      q_m_c      = '0;
      q_m_c[0]   = d_i[0];
      for (int i = 1; i < 8; i++)
         q_m_c[i] = use_xnor_c ? ~(q_m_c[i-1] ^ d_i[i]) : (q_m_c[i-1] ^ d_i[i]);
      q_m_c[8] = ~use_xnor_c;
   end

   // Stage 2: steer running disparity toward zero; diff_c is N1-N0.
   always_comb begin
      n1m_c = '0;
      for (int i = 0; i < 8; i++) n1m_c = n1m_c + 4'(q_m_q[i]);
      diff_c = disp_t'(n1m_c) - disp_t'(4'd8 - n1m_c);
      sym_d  = '0;
      cnt_d  = cnt_q;
      if (!de_q) begin
         sym_d = ctrl_sym(c_q);
         cnt_d = '0;
      end else if ((cnt_q == '0) || (diff_c == '0)) begin
         sym_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
         cnt_d = q_m_q[8] ? (cnt_q + diff_c) : (cnt_q - diff_c);
      end else if (cnt_q[CNT_W-1] == diff_c[CNT_W-1]) begin
         sym_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
         cnt_d = cnt_q + disp_t'({q_m_q[8], 1'b0}) - diff_c;
      end else begin
         sym_d = {1'b0, q_m_q[8], q_m_q[7:0]};
         cnt_d = cnt_q + diff_c - disp_t'({~q_m_q[8], 1'b0});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_m_q <= '0;
         de_q  <= 1'b0;
         c_q   <= '0;
         sym_q <= CTRL_00;
         cnt_q <= '0;
      end else begin
         q_m_q <= q_m_c;
         de_q  <= de_i;
         c_q   <= c_i;
         sym_q <= sym_d;
         cnt_q <= cnt_d;
      end
   end

   assign sym_o = sym_q;

endmodule

// File: rtl/tmds_encoder.sv
// DVI TMDS encoder top: optional colour-bar substitution and sync steering.
// Colour bars are built only when TMDS_COLORBAR_EN is defined.
module tmds_encoder
   import tmds_pkg::*;
#(
   parameter int unsigned HORZ_PIX = 1024
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        de,
   input  logic [1:0]  vh,
   input  logic [10:0] x,
   input  logic [23:0] rgb,
   input  logic        pat_en,
   output sym_t        tmds_b,
   output sym_t        tmds_g,
   output sym_t        tmds_r
);

   pix_t pix_c;

`ifdef TMDS_COLORBAR_EN
   localparam int unsigned BAR_W = HORZ_PIX / 8;

   logic [10:0] bar_c;
   logic [2:0]  idx_c;

   always_comb begin
      bar_c = x / 11'(BAR_W);
      idx_c = (bar_c > 11'd7) ? 3'd7 : bar_c[2:0];
      pix_c = pat_en ? bar_colour(idx_c) : pix_t'(rgb);
   end
`else
   logic unused_c;
   assign unused_c = ^{x, pat_en, 11'(HORZ_PIX)};

   always_comb pix_c = pix_t'(rgb);
`endif

   // Only blue carries hsync/vsync during blanking.
   tmds_channel u_ch_b (
      .clk   (clk),
      .rst   (rst),
      .de_i  (de),
      .c_i   (vh),
      .d_i   (pix_c.b),
      .sym_o (tmds_b)
   );

   tmds_channel u_ch_g (
      .clk   (clk),
      .rst   (rst),
      .de_i  (de),
      .c_i   (2'b00),
      .d_i   (pix_c.g),
      .sym_o (tmds_g)
   );

   tmds_channel u_ch_r (
      .clk   (clk),
      .rst   (rst),
      .de_i  (de),
      .c_i   (2'b00),
      .d_i   (pix_c.r),
      .sym_o (tmds_r)
   );

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: integer reference model checked every cycle plus directed literal vectors.
module tb_tmds_encoder;
   import tmds_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tmds_if bus();

   tmds_encoder #(.HORZ_PIX(1024)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .de     (bus.de),
      .vh     (bus.vh),
      .x      (bus.x),
      .rgb    (bus.rgb),
      .pat_en (bus.pat_en),
      .tmds_b (bus.tmds_b),
      .tmds_g (bus.tmds_g),
      .tmds_r (bus.tmds_r)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [9:0]  ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
   logic [23:0] bar_tab  [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   task automatic chk_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoder straight from the DVI rules, unbounded integer disparity.
   function automatic logic [9:0] ref_enc(input logic [7:0] d, input int cin, output int cout);
      logic [8:0] qm;
      logic [9:0] res;
      int         n1, ones, zeros;
      bit         xn;
      n1    = $countones(d);
      xn    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm    = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      ones  = $countones(qm[7:0]);
      zeros = 8 - ones;
      if (cin == 0 || ones == zeros) begin
         if (qm[8]) begin res = {2'b01, qm[7:0]};  cout = cin + ones - zeros; end
         else       begin res = {2'b10, ~qm[7:0]}; cout = cin + zeros - ones; end
      end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
         res  = {1'b1, qm[8], ~qm[7:0]};
         cout = cin + 2 * int'(qm[8]) + zeros - ones;
      end else begin
         res  = {1'b0, qm[8], qm[7:0]};
         cout = cin + ones - zeros - (qm[8] ? 0 : 2);
      end
      return res;
   endfunction

   function automatic logic [7:0] dec(input logic [9:0] s);
      logic [7:0] q, d;
      q    = s[9] ? ~s[7:0] : s[7:0];
      d    = '0;
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   function automatic logic [23:0] eff_rgb(input logic [23:0] c, input logic [10:0] xp, input logic pe);
`ifdef TMDS_COLORBAR_EN
      int idx;
      idx = int'(xp) / 128;
      if (idx > 7) idx = 7;
      return pe ? bar_tab[idx] : c;
`else
      return (pe & xp[0] & 1'b0) ? 24'h0 : c;
`endif
   endfunction

   // Model: what each edge presents two edges later.
   bit          mval = 1'b0;
   logic        s_de;
   logic [1:0]  s_vh;
   logic [23:0] s_rgb;
   logic [9:0]  exp_sym [3];
   int          mcnt    [3];

   always @(posedge clk) begin
      if (rst) begin
         mval  = 1'b1;
         s_de  = 1'b0;
         s_vh  = 2'b00;
         s_rgb = '0;
         for (int c = 0; c < 3; c++) begin exp_sym[c] = ctrl_tab[0]; mcnt[c] = 0; end
      end else begin
         for (int c = 0; c < 3; c++) begin
            if (!s_de) begin
               exp_sym[c] = ctrl_tab[(c == 0) ? int'(s_vh) : 0];
               mcnt[c]    = 0;
            end else begin
               int nc;
               exp_sym[c] = ref_enc(s_rgb[8*c +: 8], mcnt[c], nc);
               mcnt[c]    = nc;
            end
         end
         s_de  = bus.de;
         s_vh  = bus.vh;
         s_rgb = eff_rgb(bus.rgb, bus.x, bus.pat_en);
      end
   end

   always @(negedge clk) begin
      if (mval) begin
         chk_sym("sym_b", bus.tmds_b, exp_sym[0]);
         chk_sym("sym_g", bus.tmds_g, exp_sym[1]);
         chk_sym("sym_r", bus.tmds_r, exp_sym[2]);
         chk_int("cnt_b", int'($signed(u_dut.u_ch_b.cnt_q)), mcnt[0]);
         chk_int("cnt_g", int'($signed(u_dut.u_ch_g.cnt_q)), mcnt[1]);
         chk_int("cnt_r", int'($signed(u_dut.u_ch_r.cnt_q)), mcnt[2]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic de_v, input logic [1:0] vh_v, input logic [10:0] x_v,
                        input logic [23:0] rgb_v, input logic pe_v);
      bus.de     = de_v;
      bus.vh     = vh_v;
      bus.x      = x_v;
      bus.rgb    = rgb_v;
      bus.pat_en = pe_v;
   endtask

   task automatic chk_all(input string name, input logic [9:0] e);
      chk_sym({name, "_b"}, bus.tmds_b, e);
      chk_sym({name, "_g"}, bus.tmds_g, e);
      chk_sym({name, "_r"}, bus.tmds_r, e);
   endtask

   // Three black pixels from zero disparity, then blanking.
   task automatic zero_line(input string tag);
      drive(1'b1, 2'b00, 11'd0, 24'h000000, 1'b0); step();
      drive(1'b1, 2'b00, 11'd1, 24'h000000, 1'b0); step();
      chk_all({tag, "_p0"}, 10'b0100000000);
      chk_int({tag, "_mcnt0"}, mcnt[0], -8);
      drive(1'b1, 2'b00, 11'd2, 24'h000000, 1'b0); step();
      chk_all({tag, "_p1"}, 10'b1111111111);
      chk_int({tag, "_mcnt1"}, mcnt[0], 2);
      drive(1'b0, 2'b00, 11'd0, 24'h000000, 1'b0); step();
      chk_all({tag, "_p2"}, 10'b0100000000);
      chk_int({tag, "_mcnt2"}, mcnt[0], -6);
      step();
      step();
      chk_int({tag, "_mcnt_blank"}, mcnt[0], 0);
   endtask

   logic [10:0] bar_x   [4] = '{11'd0, 11'd127, 11'd128, 11'd1023};
   logic [23:0] bar_exp [4];

   initial begin
      rst = 1'b1;
      drive(1'b0, 2'b00, 11'd0, 24'h0, 1'b0);

      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("reset", 10'b1101010100);
      end

      rst = 1'b0;
      drive(1'b0, 2'b01, 11'd0, 24'h0, 1'b0);
      step();
      step();
      chk_sym("hsync_b", bus.tmds_b, 10'b0010101011);
      chk_sym("hsync_g", bus.tmds_g, 10'b1101010100);
      chk_sym("hsync_r", bus.tmds_r, 10'b1101010100);

      zero_line("black");

      drive(1'b1, 2'b00, 11'd0, 24'h0000FF, 1'b0); step();
      drive(1'b0, 2'b00, 11'd0, 24'h000000, 1'b0); step();
      chk_sym("blue_ff_b", bus.tmds_b, 10'b1000000000);
      chk_sym("blue_ff_g", bus.tmds_g, 10'b0100000000);
      chk_int("blue_ff_mcnt", mcnt[0], -8);
      step();
      step();

      // Random lines; sync bits toggle during active video and must be ignored.
      for (int ln = 0; ln < 6; ln++) begin
         for (int p = 0; p < 160; p++) begin
            drive(1'b1, 2'($urandom_range(3)), 11'(p), 24'($urandom), 1'b0);
            step();
         end
         for (int b = 0; b < 12; b++) begin
            drive(1'b0, {1'b0, (b >= 2 && b < 6)}, 11'd0, 24'h0, 1'b0);
            step();
         end
      end

      // Mid-line reset flushes the pipe.
      for (int p = 0; p < 20; p++) begin
         drive(1'b1, 2'b00, 11'(p), 24'($urandom), 1'b0);
         step();
      end
      rst = 1'b1;
      step();
      chk_all("midrst", 10'b1101010100);
      chk_int("midrst_cnt", int'($signed(u_dut.u_ch_b.cnt_q)), 0);
      rst = 1'b0;
      drive(1'b0, 2'b00, 11'd0, 24'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("postrst", 10'b1101010100);
      end
      zero_line("relined");

      // Pattern generator probe: decode the first symbol of each lone pixel.
`ifdef TMDS_COLORBAR_EN
      bar_exp = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h000000};
`else
      bar_exp = '{24'h123456, 24'h123456, 24'h123456, 24'h123456};
`endif
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 2'b00, bar_x[k], 24'h123456, 1'b1); step();
         drive(1'b0, 2'b00, 11'd0, 24'h0, 1'b0);           step();
         n_cmp++;
         if ({dec(bus.tmds_r), dec(bus.tmds_g), dec(bus.tmds_b)} !== bar_exp[k]) begin
            n_err++;
            $display("FAIL bar_x%0d: got %h want %h", bar_x[k],
                     {dec(bus.tmds_r), dec(bus.tmds_g), dec(bus.tmds_b)}, bar_exp[k]);
         end
         step();
         step();
      end

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 SHALL have parameter HORZ_PIX, default 1024: active pixels per line, used for colour-bar width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port de, input, 1 bit: data enable from the timing generator.
REQ-005 SHALL have port vh, input, 2 bits: vh[0] = hsync, vh[1] = vsync.
REQ-006 SHALL have port x, input, 11 bits: horizontal pixel coordinate.
REQ-007 SHALL have port rgb, input, 24 bits: [23:16] R, [15:8] G, [7:0] B.
REQ-008 SHALL have port pat_en, input, 1 bit: selects the colour-bar pattern (see Configuration).
REQ-009 SHALL have ports tmds_b, tmds_g and tmds_r, output, 10 bits each: encoded symbols for channels 0, 1 and 2.

Function
REQ-010 SHALL treat de, vh, x, rgb and pat_en as sampled in the same cycle; latency from inputs to symbols is exactly 2 clk cycles.
REQ-011 Stage 1 SHALL count ones n1 in the 8-bit data byte d and register the 9-bit minimised word q_m, plus de and vh.
- XNOR chain with q_m[8]=0 if n1>4, or if n1==4 and d[0]==0.
- Otherwise XOR chain with q_m[8]=1.
- q_m[0]=d[0] in both cases.
REQ-012 Stage 2 SHALL select the DC-balanced output per DVI 1.0 using a per-channel signed 5-bit disparity counter cnt; N1/N0 are the ones/zeros in q_m[7:0].
- Case A, cnt==0 or N1==N0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m[8] ? (N1-N0) : (N0-N1).
- Case B, (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out = {1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (N0-N1).
- Case C, otherwise: out = {0, q_m[8], q_m[7:0]}; cnt += (N1-N0) - 2*(~q_m[8]).
REQ-013 When stage-2 de==0, each channel SHALL emit its control symbol and clear cnt to 0.
- c=00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
- Blue uses c={vh[1],vh[0]}; green and red use c=00.
REQ-014 When de==1, vh SHALL be ignored; simultaneous de and sync produce data symbols only.
REQ-015 cnt SHALL be 5-bit two's complement and never wrap for any input sequence.
REQ-016 Symbols SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-017 While rst==1, all pipeline registers SHALL be cleared: de=0, vh=00, q_m=0, cnt=0 on all channels.
REQ-018 All outputs SHALL read 1101010100 from the first edge with rst high; the first valid symbol appears 2 cycles after the first post-reset input.
REQ-019 Reset asserted mid-line SHALL flush the in-flight pixels; no data symbol emerges after reset.

Configuration
REQ-020 The feature macro SHALL be TMDS_COLORBAR_EN.
- Defined, pat_en==1: rgb is replaced before stage 1 with bar index x/(HORZ_PIX/8), clamped to 7.
- Bar colours in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Defined, pat_en==0: rgb passes unchanged.
- Undefined: x and pat_en are ignored and rgb always passes; latency is unchanged either way.

Structure
REQ-021 Package tmds_pkg SHALL hold the four control-symbol constants, a typedef for the 10-bit symbol and a typedef for the signed 5-bit disparity.
REQ-022 A sub-module tmds_channel (stage 1 + stage 2 + cnt for one byte) SHALL be instantiated three times; tmds_encoder holds only pattern muxing and control-bit steering.

Verification
REQ-023 rst=1 for 3 cycles -> all channels 1101010100; after release with de=0, vh=01 -> tmds_b=0010101011 two cycles later, tmds_g=tmds_r=1101010100.
REQ-024 de=1, rgb=000000 for 3 pixels from cnt=0 -> each channel emits 0100000000, 1111111111, 0100000000; cnt goes -8, 2, -6.
REQ-025 de=1, B=FF from cnt=0 -> tmds_b=1000000000 and cnt=-8.
REQ-026 Random rgb for 10^5 pixels checked against a reference model -> exact symbol match; per-line running disparity bounded; cnt back to 0 at every de fall.
REQ-027 rst pulsed mid-line with de=1 -> control symbols within 1 cycle and cnt=0; the next line encodes identically to a fresh start.
REQ-028 With TMDS_COLORBAR_EN defined, pat_en=1, HORZ_PIX=1024 and x=0,127,128,1023 -> decoded bytes FFFFFF, FFFFFF, FFFF00, 000000; without the macro the rgb input is encoded instead.
